// File: rtl/hazard_unit.sv
// Hazard/forwarding control for the 5-stage RV32I pipeline: load-use stall, branch flush,
// memory freeze with deferred flush, plus saturating stall/flush counters.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D_i,
  input  logic [REG_ADDR_W-1:0] Rs2D_i,
  input  logic [REG_ADDR_W-1:0] Rs1E_i,
  input  logic [REG_ADDR_W-1:0] Rs2E_i,
  input  logic [REG_ADDR_W-1:0] RdE_i,
  input  logic                  LoadE_i,
  input  logic [REG_ADDR_W-1:0] RdM_i,
  input  logic                  RegWriteM_i,
  input  logic [REG_ADDR_W-1:0] RdW_i,
  input  logic                  RegWriteW_i,
  input  logic                  PCSrcE_i,
  input  logic                  MemBusyM_i,
  output logic                  StallF_o,
  output logic                  StallD_o,
  output logic                  StallE_o,
  output logic                  StallM_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic [1:0]            ForwardAE_o,
  output logic [1:0]            ForwardBE_o,
  output logic [CNT_W-1:0]      StallCnt_o,
  output logic [CNT_W-1:0]      FlushCnt_o
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic stall_f_s, stall_d_s, stall_e_s, stall_m_s, flush_d_s, flush_e_s;
  logic lw_hit_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  // Memory-stage result is younger than writeback, so it wins; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic [REG_ADDR_W-1:0] rd_m,
                                         input logic                  wr_m,
                                         input logic [REG_ADDR_W-1:0] rd_w,
                                         input logic                  wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (en && (cnt != CNT_ONES)) begin
      res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  assign lw_hit_s = LoadE_i && (RdE_i != REG_ZERO) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
  assign fwd_a_s  = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
  assign fwd_b_s  = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);

  // Next-state and pipeline control; a memory freeze overrides both load-use and branch handling.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    case (state_q)
      RUN: begin
        if (MemBusyM_i) begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
          pend_d  = PCSrcE_i;
          state_d = MEM_WAIT;
        end else if (PCSrcE_i) begin
          {flush_d_s, flush_e_s} = 2'b11;
        end else if (lw_hit_s) begin
          {stall_f_s, stall_d_s, flush_e_s} = 3'b111;
        end else begin
          pend_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (MemBusyM_i) begin
          {stall_f_s, stall_d_s, stall_e_s, stall_m_s} = 4'b1111;
          pend_d = pend_q | PCSrcE_i;
        end else begin
          pend_d  = 1'b0;
          state_d = RUN;
          if (pend_q || PCSrcE_i) begin
            {flush_d_s, flush_e_s} = 2'b11;
          end else if (lw_hit_s) begin
            {stall_f_s, stall_d_s, flush_e_s} = 3'b111;
          end else begin
            flush_e_s = 1'b0;
          end
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Everything is forced low while reset is held, including the forwarding selects.
  assign StallF_o    = rst_n & stall_f_s;
  assign StallD_o    = rst_n & stall_d_s;
  assign StallE_o    = rst_n & stall_e_s;
  assign StallM_o    = rst_n & stall_m_s;
  assign FlushD_o    = rst_n & flush_d_s;
  assign FlushE_o    = rst_n & flush_e_s;
  assign ForwardAE_o = {2{rst_n}} & fwd_a_s;
  assign ForwardBE_o = {2{rst_n}} & fwd_b_s;
  assign StallCnt_o  = stall_cnt_q;
  assign FlushCnt_o  = flush_cnt_q;

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, StallF_o);
    flush_cnt_d = sat_inc(flush_cnt_q, FlushE_o);
  end

  // State, deferred-flush flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      stall_cnt_q <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected control vectors go through a scoreboard queue,
// counters are checked against a bench-side saturating model.
module tb_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic        LoadE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i, MemBusyM_i;
  logic        StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o;
  logic [1:0]  ForwardAE_o, ForwardBE_o;
  logic [15:0] StallCnt_o, FlushCnt_o;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          total;
  int          passed;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .LoadE_i(LoadE_i), .RdM_i(RdM_i), .RegWriteM_i(RegWriteM_i),
    .RdW_i(RdW_i), .RegWriteW_i(RegWriteW_i), .PCSrcE_i(PCSrcE_i), .MemBusyM_i(MemBusyM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [9:0] obs_vec();
    return {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, ForwardAE_o, ForwardBE_o};
  endfunction

  task automatic idle();
    Rs1D_i = 5'd0; Rs2D_i = 5'd0; Rs1E_i = 5'd0; Rs2E_i = 5'd0;
    RdE_i = 5'd0; RdM_i = 5'd0; RdW_i = 5'd0;
    LoadE_i = 1'b0; RegWriteM_i = 1'b0; RegWriteW_i = 1'b0;
    PCSrcE_i = 1'b0; MemBusyM_i = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; expected vector is
  // {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}.
  task automatic step(input string tag, input logic [9:0] exp);
    sb_t it;
    sb.push_back('{tag, exp});
    @(negedge clk);
    it = sb.pop_front();
    chk(it.tag, {22'd0, obs_vec()}, {22'd0, it.exp});
    if (it.exp[9]) m_stall = sat16(m_stall);
    if (it.exp[4]) m_flush = sat16(m_flush);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stallcnt"}, {16'd0, StallCnt_o}, {16'd0, m_stall});
    chk({tag, "_flushcnt"}, {16'd0, FlushCnt_o}, {16'd0, m_flush});
  endtask

  initial begin
    total = 0; passed = 0; m_stall = 16'd0; m_flush = 16'd0;
    idle();
    rst_n = 1'b0;
    RegWriteM_i = 1'b1; RdM_i = 5'd5; Rs1E_i = 5'd5; MemBusyM_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, obs_vec()}, 32'd0);
    chk_cnt("reset");
    idle();
    rst_n = 1'b1;

    // Forwarding priority and x0 exclusion.
    RegWriteM_i = 1'b1; RdM_i = 5'd5; Rs1E_i = 5'd5; RegWriteW_i = 1'b1; RdW_i = 5'd5;
    step("fwdA_mem", 10'b000000_10_00);
    RdM_i = 5'd0;
    step("fwdA_wb_rdm0", 10'b000000_01_00);
    Rs2E_i = 5'd5; RdM_i = 5'd5;
    step("fwdAB_mem", 10'b000000_10_10);
    RegWriteM_i = 1'b0; Rs1E_i = 5'd7;
    step("fwdB_wb", 10'b000000_00_01);
    RdW_i = 5'd0; Rs2E_i = 5'd0;
    step("fwd_x0", 10'b000000_00_00);
    idle();

    // Load-use, then branch beating load-use.
    LoadE_i = 1'b1; RdE_i = 5'd3; Rs2D_i = 5'd3;
    step("loaduse", 10'b110001_00_00);
    chk_cnt("loaduse");
    RdE_i = 5'd0; Rs2D_i = 5'd0;
    step("load_rd0", 10'b000000_00_00);
    RdE_i = 5'd3; Rs1D_i = 5'd3; PCSrcE_i = 1'b1;
    step("branch_over_lw", 10'b000011_00_00);
    chk_cnt("branch");
    idle();
    step("idle", 10'b000000_00_00);

    // Three-cycle freeze with branch in the first cycle; flush once on release.
    MemBusyM_i = 1'b1; PCSrcE_i = 1'b1;
    step("freeze1", 10'b111100_00_00);
    PCSrcE_i = 1'b0; LoadE_i = 1'b1; RdE_i = 5'd4; Rs1D_i = 5'd4;
    step("freeze2_lw", 10'b111100_00_00);
    step("freeze3", 10'b111100_00_00);
    MemBusyM_i = 1'b0; LoadE_i = 1'b0;
    step("release_flush", 10'b000011_00_00);
    step("after_release", 10'b000000_00_00);
    chk_cnt("freeze");

    // Release without pending flush applies the load-use rule.
    MemBusyM_i = 1'b1;
    step("freeze_nobr", 10'b111100_00_00);
    MemBusyM_i = 1'b0; LoadE_i = 1'b1; RdE_i = 5'd9; Rs2D_i = 5'd9;
    step("release_lw", 10'b110001_00_00);
    idle();

    // Reset asserted mid-freeze with a pending flush.
    MemBusyM_i = 1'b1; PCSrcE_i = 1'b1;
    step("freeze_pre_rst", 10'b111100_00_00);
    PCSrcE_i = 1'b0; RegWriteM_i = 1'b1; RdM_i = 5'd6; Rs1E_i = 5'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_midfreeze", {22'd0, obs_vec()}, 32'd0);
    m_stall = 16'd0; m_flush = 16'd0;
    chk_cnt("rst_midfreeze");
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    step("post_rst_noflush", 10'b000000_00_00);
    step("post_rst_idle", 10'b000000_00_00);

    // Counter saturation.
    LoadE_i = 1'b1; RdE_i = 5'd3; Rs2D_i = 5'd3;
    for (int i = 0; i < 65538; i++) begin
      @(posedge clk);
      m_stall = sat16(m_stall);
      m_flush = sat16(m_flush);
    end
    #1;
    chk("stallcnt_sat", {16'd0, StallCnt_o}, 32'h0000FFFF);
    chk_cnt("saturate");
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
